// File: rtl/is_pkg_uart_controller.sv
// is_pkg_uart_controller: shared types and constants for the UART controller receive path.
package is_pkg_uart_controller;
  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_t;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_BRK
  } rx_state_t;
  localparam int RX_DATA_W_MIN = 5;
  localparam int RX_DATA_W_MAX = 9;
  // Parity bit the line should carry, given the XOR of the received data bits.
  function automatic logic parity_expected(parity_mode_t mode, logic data_xor);
    return mode == PAR_EVEN ? data_xor :
           mode == PAR_ODD  ? ~data_xor :
           mode == PAR_MARK ? 1'b1 : 1'b0;
  endfunction
endpackage

// File: rtl/is_uart_rx_sync.sv
// is_uart_rx_sync: 2-FF synchroniser for an idle-high serial line plus falling-edge detect.
module is_uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic fall_o
);
  logic [2:0] sr;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sr <= 3'b111;
    else sr <= {sr[1:0], rxd_i};
  assign rxd_s_o = sr[1];
  assign fall_o  = sr[2] & ~sr[1];
endmodule

// File: rtl/is_uart_rx_core.sv
// is_uart_rx_core: oversampling UART receiver with runtime parity, 1/2 stop bits and break detect.
module is_uart_rx_core
  import is_pkg_uart_controller::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              os_tick_i,
  input  logic              rxd_i,
  input  parity_mode_t      parity_mode_i,
  input  logic              stop2_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              break_o,
  output logic              busy_o
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_HALF   = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  if (DATA_W < RX_DATA_W_MIN || DATA_W > RX_DATA_W_MAX) begin : g_bad_data_w
    $error("is_uart_rx_core: DATA_W out of range");
  end
  if (OVS < 8 || OVS > 32 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("is_uart_rx_core: OVS must be even and within 8..32");
  end
  rx_state_t         state;
  parity_mode_t      mode_q;
  logic              stop2_q;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sr;
  logic              zero_q, par_err_q, frm_err_q;
  logic              rxd_s, fall, sample, zero_n, frm_n;
  is_uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rxd_i   (rxd_i),
    .rxd_s_o (rxd_s),
    .fall_o  (fall)
  );
  assign sample = tick_cnt == (state == RX_START ? T_HALF : T_FULL);
  // Break needs every sampled bit low, including the one being sampled now.
  assign zero_n = zero_q & ~rxd_s;
  assign frm_n  = frm_err_q | ~rxd_s;
  assign busy_o = state != RX_IDLE;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state        <= RX_IDLE;
      mode_q       <= PAR_NONE;
      stop2_q      <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      zero_q       <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      break_o    <= 1'b0;
      if (state == RX_IDLE) begin
        mode_q  <= parity_mode_i;
        stop2_q <= stop2_i;
        if (fall) begin
          state    <= RX_START;
          tick_cnt <= '0;
        end
      end else if (state == RX_BRK) begin
        if (os_tick_i && rxd_s) state <= RX_IDLE;
      end else if (os_tick_i) begin
        if (!sample) tick_cnt <= tick_cnt + 1'b1;
        else begin
          tick_cnt <= '0;
          case (state)
            RX_START: begin
              state     <= rxd_s ? RX_IDLE : RX_DATA;
              bit_cnt   <= '0;
              zero_q    <= 1'b1;
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
            end
            RX_DATA: begin
              sr      <= {rxd_s, sr[DATA_W-1:1]};
              zero_q  <= zero_n;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= mode_q == PAR_NONE ? RX_STOP1 : RX_PARITY;
            end
            RX_PARITY: begin
              par_err_q <= rxd_s != parity_expected(mode_q, ^sr);
              zero_q    <= zero_n;
              state     <= RX_STOP1;
            end
            RX_STOP1, RX_STOP2: begin
              frm_err_q <= frm_n;
              zero_q    <= zero_n;
              if (state == RX_STOP1 && stop2_q) state <= RX_STOP2;
              else if (zero_n) begin
                break_o <= 1'b1;
                state   <= RX_BRK;
              end else begin
                rx_data_o    <= sr;
                parity_err_o <= par_err_q;
                frame_err_o  <= frm_n;
                rx_valid_o   <= 1'b1;
                state        <= RX_IDLE;
              end
            end
            default: state <= RX_IDLE;
          endcase
        end
      end
    end
endmodule

// File: tb/tb_is_uart_rx_core.sv
// tb_is_uart_rx_core: table-driven, hand-written and random frame checks against a frame-level model.
module tb_is_uart_rx_core;
  import is_pkg_uart_controller::*;
  localparam int DIV = 3;
  localparam int BIT = 16 * DIV;
  typedef struct {
    logic [7:0]   d;
    parity_mode_t m;
    logic         s2;
    logic         pb;
    logic [1:0]   st;
    logic [7:0]   ed;
    logic         ep;
    logic         ef;
  } vec_t;
  logic clk = 0, rst = 1, os_tick = 0, rxd = 1, stop2 = 0;
  parity_mode_t pmode = PAR_NONE;
  logic [7:0] rx_data;
  logic rx_valid, perr, ferr, brk, busy;
  int errors = 0, checks = 0, valid_cnt = 0, brk_cnt = 0;
  vec_t tbl[8];
  always #5 clk = ~clk;
  is_uart_rx_core #(.DATA_W(8), .OVS(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .os_tick_i     (os_tick),
    .rxd_i         (rxd),
    .parity_mode_i (pmode),
    .stop2_i       (stop2),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .parity_err_o  (perr),
    .frame_err_o   (ferr),
    .break_o       (brk),
    .busy_o        (busy)
  );
  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      os_tick = (div == DIV - 1);
      div = (div + 1) % DIV;
    end
  end
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_valid: got %0b, expected 0", busy);
      end
    end
    if (brk) brk_cnt++;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic hold(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input parity_mode_t m, input logic s2, input logic pb, input logic [1:0] st);
    pmode = m;
    stop2 = s2;
    hold(1'b1, 4);
    hold(1'b0, BIT);
    pmode = parity_mode_t'($urandom_range(0, 4));
    stop2 = 1'($urandom);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (m != PAR_NONE) hold(pb, BIT);
    hold(st[0], BIT);
    if (s2) hold(st[1], BIT);
    hold(1'b1, BIT);
  endtask
  function automatic void model(input logic [7:0] d, input parity_mode_t m, input logic s2, input logic pb,
                                input logic [1:0] st, output logic ep, output logic ef, output logic eb);
    int ones;
    logic want;
    ones = $countones(d);
    case (m)
      PAR_EVEN: want = (ones % 2) == 1;
      PAR_ODD:  want = (ones % 2) == 0;
      PAR_MARK: want = 1'b1;
      default:  want = 1'b0;
    endcase
    ep = (m != PAR_NONE) && (pb != want);
    ef = !st[0] || (s2 && !st[1]);
    eb = (d == 8'h00) && (m == PAR_NONE || !pb) && !st[0] && (!s2 || !st[1]);
  endfunction
  task automatic run(input string tag, input vec_t v, input logic eb);
    int v0, b0;
    v0 = valid_cnt;
    b0 = brk_cnt;
    send(v.d, v.m, v.s2, v.pb, v.st);
    if (eb) begin
      check({tag, "_break_pulses"}, brk_cnt - b0, 1);
      check({tag, "_valid_pulses"}, valid_cnt - v0, 0);
    end else begin
      check({tag, "_valid_pulses"}, valid_cnt - v0, 1);
      check({tag, "_break_pulses"}, brk_cnt - b0, 0);
      check({tag, "_data"}, rx_data, v.ed);
      check({tag, "_parity_err"}, perr, v.ep);
      check({tag, "_frame_err"}, ferr, v.ef);
    end
    check({tag, "_busy_idle"}, busy, 0);
  endtask
  initial begin
    vec_t v;
    logic ep, ef, eb;
    int v0, b0, n;
    tbl[0] = '{8'hA5, PAR_EVEN,  1'b0, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, PAR_ODD,   1'b0, 1'b0, 2'b11, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{8'h5A, PAR_NONE,  1'b1, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, PAR_MARK,  1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h00, PAR_SPACE, 1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h80, PAR_MARK,  1'b1, 1'b0, 2'b11, 8'h80, 1'b1, 1'b0};
    tbl[6] = '{8'h01, PAR_EVEN,  1'b0, 1'b1, 2'b10, 8'h01, 1'b0, 1'b1};
    tbl[7] = '{8'h7E, PAR_SPACE, 1'b1, 1'b1, 2'b11, 8'h7E, 1'b1, 1'b0};
    repeat (4) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_flags", {perr, ferr, brk}, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    hold(1'b1, BIT);
    for (int i = 0; i < 8; i++) run($sformatf("tbl%0d", i), tbl[i], 1'b0);
    v0 = valid_cnt;
    hold(1'b0, 15);
    check("false_busy_hi", busy, 1);
    rxd = 1'b1;
    n = 0;
    while (busy && n < (16 / 2 + 3) * DIV) begin
      @(negedge clk);
      n++;
    end
    check("false_busy_lo", busy, 0);
    hold(1'b1, BIT);
    check("false_no_valid", valid_cnt - v0, 0);
    pmode = PAR_EVEN;
    stop2 = 1'b0;
    v0 = valid_cnt;
    b0 = brk_cnt;
    hold(1'b1, 4);
    hold(1'b0, 2 * 11 * BIT);
    check("brk_busy_while_low", busy, 1);
    hold(1'b1, 2 * BIT);
    check("brk_pulses", brk_cnt - b0, 1);
    check("brk_no_valid", valid_cnt - v0, 0);
    check("brk_busy_lo", busy, 0);
    run("post_brk", '{8'h55, PAR_EVEN, 1'b0, 1'b0, 2'b11, 8'h55, 1'b0, 1'b0}, 1'b0);
    pmode = PAR_NONE;
    stop2 = 1'b0;
    v0 = valid_cnt;
    hold(1'b1, 4);
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    hold(1'b0, BIT);
    hold(1'b0, BIT / 2);
    rst = 1'b1;
    #1;
    check("midrst_data", rx_data, 0);
    check("midrst_flags", {rx_valid, perr, ferr, brk}, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 2 * BIT);
    check("midrst_no_valid", valid_cnt - v0, 0);
    run("post_rst", '{8'h81, PAR_NONE, 1'b0, 1'b0, 2'b11, 8'h81, 1'b0, 1'b0}, 1'b0);
    for (int i = 0; i < 24; i++) begin
      v.d  = 8'($urandom);
      v.m  = parity_mode_t'($urandom_range(0, 4));
      v.s2 = 1'($urandom);
      v.pb = 1'($urandom);
      v.st = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      if ($urandom_range(0, 5) == 0) begin
        v.d  = 8'h00;
        v.pb = 1'b0;
        v.st = 2'b00;
      end
      model(v.d, v.m, v.s2, v.pb, v.st, ep, ef, eb);
      v.ed = v.d;
      v.ep = ep;
      v.ef = ef;
      run($sformatf("rnd%0d", i), v, eb);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
